// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: an Avalon-MM read master that fetches the
// system ID (word 0) and the build timestamp (word 1), compares both against
// the values this bitstream was built with, and reports done/match/error so
// motor enable can be gated on a verified build. Each read attempt has a
// cycle budget and a bounded number of retries so a dead slave cannot hang boot.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h04000000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1417733210,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        error
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  // The attempt is abandoned on the edge where the count would reach the budget.
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RetryMax    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    CHECK,
    DONE,
    FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timeoutCnt_q, timeoutCnt_d;
  logic [RW-1:0]   retryCnt_q, retryCnt_d;
  logic [31:0]     idValue_q, idValue_d;
  logic [31:0]     tsValue_q, tsValue_d;
  logic            match_q, match_d;
  logic            autoStart_q;
  logic            isTsWord;
  logic            timedOut;
  logic            abortAttempt;

  // Register all sequencing state; autoStart_q makes the first edge after
  // reset release behave as a start pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      retryCnt_q   <= '0;
      idValue_q    <= '0;
      tsValue_q    <= '0;
      match_q      <= 1'b0;
      autoStart_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      timeoutCnt_q <= timeoutCnt_d;
      retryCnt_q   <= retryCnt_d;
      idValue_q    <= idValue_d;
      tsValue_q    <= tsValue_d;
      match_q      <= match_d;
      autoStart_q  <= 1'b0;
    end
  end

  // Next-state logic: issue each read, wait for its response, retry on
  // timeout, and finally compare the captured words.
  always_comb begin
    state_d      = state_q;
    timeoutCnt_d = timeoutCnt_q;
    retryCnt_d   = retryCnt_q;
    idValue_d    = idValue_q;
    tsValue_d    = tsValue_q;
    match_d      = match_q;
    abortAttempt = 1'b0;
    isTsWord     = (state_q == REQ_TS) || (state_q == WAIT_TS);
    timedOut     = (timeoutCnt_q == TimeoutLast);

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start || autoStart_q) begin
          state_d      = REQ_ID;
          match_d      = 1'b0;
          retryCnt_d   = '0;
          timeoutCnt_d = '0;
        end
      end
      REQ_ID, REQ_TS: begin
        timeoutCnt_d = timeoutCnt_q + TW'(1);
        if (timedOut) begin
          abortAttempt = 1'b1;
        end else if (!m_waitrequest) begin
          state_d = isTsWord ? WAIT_TS : WAIT_ID;
        end
      end
      WAIT_ID, WAIT_TS: begin
        timeoutCnt_d = timeoutCnt_q + TW'(1);
        // A response on the timeout edge still counts: data beats the abort.
        if (m_readdatavalid) begin
          timeoutCnt_d = '0;
          retryCnt_d   = '0;
          if (isTsWord) begin
            tsValue_d = m_readdata;
            state_d   = CHECK;
          end else begin
            idValue_d = m_readdata;
            state_d   = REQ_TS;
          end
        end else if (timedOut) begin
          abortAttempt = 1'b1;
        end
      end
      CHECK: begin
        match_d = (idValue_q == EXPECTED_ID) && (tsValue_q == EXPECTED_TS);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abortAttempt) begin
      timeoutCnt_d = '0;
      if (retryCnt_q < RetryMax) begin
        retryCnt_d = retryCnt_q + RW'(1);
        state_d    = isTsWord ? REQ_TS : REQ_ID;
      end else begin
        state_d = FAIL;
      end
    end
  end

  // Bus strobes and status flags decode straight from the state so an
  // asynchronous reset clears them immediately.
  always_comb begin
    m_read    = (state_q == REQ_ID) || (state_q == REQ_TS);
    m_address = (state_q == REQ_TS) || (state_q == WAIT_TS);
    busy      = (state_q == REQ_ID) || (state_q == WAIT_ID) ||
                (state_q == REQ_TS) || (state_q == WAIT_TS) ||
                (state_q == CHECK);
    done      = (state_q == DONE);
    error     = (state_q == FAIL);
    match     = match_q;
    id_value  = idValue_q;
    ts_value  = tsValue_q;
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed testbench for sysid_boot_checker: a small behavioural Avalon slave
// answers reads, and each scenario task checks the checker's outputs against
// hand-computed values at known edge counts after reset release or start.
module tb_sysid_boot_checker;

  localparam logic [31:0] ExpId = 32'h04000000;
  localparam logic [31:0] ExpTs = 32'd1417733210;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = 32'h0;
  logic        m_readdatavalid = 1'b0;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        busy;
  logic        done;
  logic        match;
  logic        error;

  int testsRun = 0;
  int failCount = 0;

  logic [31:0] idWord = ExpId;
  logic [31:0] tsWord = ExpTs;
  bit          dropTs = 1'b0;
  int          idStallCfg = 0;
  int          injectReq = 0;
  int          injectDone = 0;
  bit          acceptPending = 1'b0;
  bit          respAddr = 1'b0;
  int          stallCnt = 0;
  int          idStarts = 0;
  int          tsStarts = 0;
  logic        prevRead = 1'b0;

  sysid_boot_checker #(
    .EXPECTED_ID   (ExpId),
    .EXPECTED_TS   (ExpTs),
    .TIMEOUT_CYCLES(8),
    .MAX_RETRIES   (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .busy           (busy),
    .done           (done),
    .match          (match),
    .error          (error)
  );

  // 10-unit clock.
  always #5 clock = ~clock;

  // Behavioural slave: optional stall on the ID read, response one cycle
  // after accept, optional silent timestamp, optional stray response.
  always @(posedge clock) begin
    #1;
    m_readdatavalid = 1'b0;
    if (!reset_n) begin
      acceptPending = 1'b0;
      stallCnt      = 0;
      m_waitrequest = 1'b0;
    end else begin
      if (acceptPending) begin
        acceptPending = 1'b0;
        if (!(respAddr && dropTs)) begin
          m_readdatavalid = 1'b1;
          m_readdata      = respAddr ? tsWord : idWord;
        end
      end else if (injectReq != injectDone && m_read && !m_address) begin
        injectDone      = injectReq;
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hDEADBEEF;
      end
      if (m_read) begin
        if (!m_address && stallCnt < idStallCfg) begin
          m_waitrequest = 1'b1;
          stallCnt      = stallCnt + 1;
        end else begin
          m_waitrequest = 1'b0;
          acceptPending = 1'b1;
          respAddr      = m_address;
        end
      end else begin
        m_waitrequest = 1'b0;
        stallCnt      = 0;
      end
    end
  end

  // Count fresh read requests per word to catch glitches and extra attempts.
  always @(negedge clock) begin
    if (reset_n && m_read && !prevRead) begin
      if (m_address) tsStarts = tsStarts + 1;
      else           idStarts = idStarts + 1;
    end
    prevRead = m_read;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    testsRun++;
    if ({m_read, m_address, busy, done, match, error} !== 6'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b expected %b",
               {m_read, m_address, busy, done, match, error}, 6'b0);
    end
    testsRun++;
    if (id_value !== 32'h0 || ts_value !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_values: got id=%h ts=%h expected 0/0", id_value, ts_value);
    end
  endtask

  task automatic test_healthy();
    int idBase;
    int tsBase;
    idBase = idStarts;
    tsBase = tsStarts;
    doReset();
    step(5);
    testsRun++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL healthy_edge5: got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    step(1);
    testsRun++;
    if ({done, match, busy, error} !== 4'b1100) begin
      failCount++;
      $display("[TB] FAIL healthy_edge6: got done/match/busy/error=%b expected 1100",
               {done, match, busy, error});
    end
    testsRun++;
    if (id_value !== ExpId || ts_value !== ExpTs) begin
      failCount++;
      $display("[TB] FAIL healthy_values: got id=%h ts=%h expected id=%h ts=%h",
               id_value, ts_value, ExpId, ExpTs);
    end
    testsRun++;
    if (idStarts - idBase !== 1 || tsStarts - tsBase !== 1) begin
      failCount++;
      $display("[TB] FAIL healthy_read_count: got id=%0d ts=%0d expected 1/1",
               idStarts - idBase, tsStarts - tsBase);
    end
  endtask

  task automatic test_ts_mismatch();
    tsWord = ExpTs + 32'd1;
    doReset();
    step(6);
    testsRun++;
    if ({done, match, error} !== 3'b100) begin
      failCount++;
      $display("[TB] FAIL mismatch_flags: got done/match/error=%b expected 100",
               {done, match, error});
    end
    testsRun++;
    if (ts_value !== 32'd1417733211) begin
      failCount++;
      $display("[TB] FAIL mismatch_ts: got %0d expected %0d", ts_value, 32'd1417733211);
    end
    tsWord = ExpTs;
  endtask

  task automatic test_wait_stall();
    idStallCfg = 3;
    doReset();
    step(1);
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (m_read !== 1'b1 || m_address !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL stall_hold_%0d: got read=%b addr=%b expected read=1 addr=0",
                 i, m_read, m_address);
      end
      step(1);
    end
    step(3);
    testsRun++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL stall_edge8: got done=%b expected 0", done);
    end
    step(1);
    testsRun++;
    if (done !== 1'b1 || match !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stall_edge9: got done=%b match=%b expected 1/1", done, match);
    end
    idStallCfg = 0;
  endtask

  task automatic test_timeout();
    int tsBase;
    dropTs = 1'b1;
    tsBase = tsStarts;
    doReset();
    step(26);
    testsRun++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL timeout_edge26: got busy=%b error=%b expected 1/0", busy, error);
    end
    step(1);
    testsRun++;
    if ({error, done, busy, match, m_read} !== 5'b10000) begin
      failCount++;
      $display("[TB] FAIL timeout_edge27: got error/done/busy/match/read=%b expected 10000",
               {error, done, busy, match, m_read});
    end
    testsRun++;
    if (id_value !== ExpId) begin
      failCount++;
      $display("[TB] FAIL timeout_id_kept: got %h expected %h", id_value, ExpId);
    end
    testsRun++;
    if (tsStarts - tsBase !== 3) begin
      failCount++;
      $display("[TB] FAIL timeout_attempts: got %0d expected 3", tsStarts - tsBase);
    end
    dropTs = 1'b0;
  endtask

  task automatic test_restart_after_fail();
    start = 1'b1;
    step(1);
    start = 1'b0;
    testsRun++;
    if ({error, busy, done} !== 3'b010) begin
      failCount++;
      $display("[TB] FAIL restart_start_edge: got error/busy/done=%b expected 010",
               {error, busy, done});
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    testsRun++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL restart_edge5: got done=%b expected 0", done);
    end
    step(1);
    testsRun++;
    if ({done, match, error} !== 3'b110) begin
      failCount++;
      $display("[TB] FAIL restart_edge6: got done/match/error=%b expected 110",
               {done, match, error});
    end
  endtask

  task automatic test_reset_midseq();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    testsRun++;
    if ({busy, m_read, m_address} !== 3'b101) begin
      failCount++;
      $display("[TB] FAIL midseq_wait_ts: got busy/read/addr=%b expected 101",
               {busy, m_read, m_address});
    end
    reset_n = 1'b0;
    #1;
    testsRun++;
    if ({m_read, m_address, busy, done, match, error} !== 6'b0 ||
        id_value !== 32'h0 || ts_value !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL midseq_async_reset: got flags=%b id=%h ts=%h expected all 0",
               {m_read, m_address, busy, done, match, error}, id_value, ts_value);
    end
    idStallCfg = 2;
    injectReq  = injectReq + 1;
    @(negedge clock);
    reset_n = 1'b1;
    step(2);
    testsRun++;
    if (id_value !== 32'h0 || m_read !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midseq_late_rdv: got id=%h read=%b expected id=0 read=1",
               id_value, m_read);
    end
    step(5);
    testsRun++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midseq_edge7: got done=%b expected 0", done);
    end
    step(1);
    testsRun++;
    if (done !== 1'b1 || match !== 1'b1 || id_value !== ExpId) begin
      failCount++;
      $display("[TB] FAIL midseq_edge8: got done=%b match=%b id=%h expected 1/1/%h",
               done, match, id_value, ExpId);
    end
    idStallCfg = 0;
  endtask

  // Scenario sequence; each task leaves the DUT in a known state for the next.
  initial begin
    test_reset();
    test_healthy();
    test_ts_mismatch();
    test_wait_stall();
    test_timeout();
    test_restart_after_fail();
    test_reset_midseq();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sequences the system-ID slave after reset, or on request.
- Reads word 0 (system ID) and then word 1 (build timestamp), and compares both against expected values.
- Publishes captured values plus done/match/error status to the stepper-control logic, which gates motor enable on a verified build.
- Per-word timeout and bounded retry keep a missing or hung slave from stalling boot.

Parameters:
- EXPECTED_ID, 32'h04000000, system ID the bitstream must report at address 0.
- EXPECTED_TS, 32'd1417733210, build timestamp expected at address 1.
- TIMEOUT_CYCLES, 255, cycles allowed per read attempt, counted from request start to readdatavalid.
- MAX_RETRIES, 3, extra attempts per word before declaring failure.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; re-runs the check when idle.
- m_address  out  1  word select: 0 = ID, 1 = timestamp.
- m_read  out  1  Avalon read strobe.
- m_waitrequest  in  1  slave stall; command is accepted on a clock edge where m_read=1 and m_waitrequest=0.
- m_readdata  in  32  read data, valid only with m_readdatavalid.
- m_readdatavalid  in  1  read response strobe.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- busy  out  1  check sequence in progress.
- done  out  1  sequence finished, successfully read both words.
- match  out  1  both captured words equal expected; valid while done=1.
- error  out  1  retries exhausted on some word.

Behaviour:
- Reset value of every output is 0: m_read, m_address, id_value, ts_value, busy, done, match, error. Internal state is IDLE with all counters 0.
- Auto-start: the first clock edge after reset_n deasserts behaves as a start pulse.
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + start (or auto-start) -> REQ_ID. On that edge: done, match, error, retry count and timeout count clear; id_value and ts_value hold until overwritten.
- start in any other state is ignored.
- REQ_x: m_read=1, m_address=0 (ID) or 1 (TS), held stable. An edge with m_waitrequest=0 -> WAIT_x, and m_read drops the next cycle.
- WAIT_x: m_read=0. An edge with m_readdatavalid=1 captures m_readdata into id_value (ID) or ts_value (TS), clears the timeout count and retry count, then:
  - WAIT_ID -> REQ_TS;
  - WAIT_TS -> CHECK.
- m_readdatavalid outside WAIT states is ignored; this discards late responses from abandoned attempts.
- Timeout counter:
  - increments every cycle in REQ_x and WAIT_x;
  - width is clog2(TIMEOUT_CYCLES+1);
  - reaching TIMEOUT_CYCLES forces an attempt abort. If that edge is in REQ_x, m_read drops; this abandonment is accepted behaviour for a dead slave.
- Abort handling:
  - retry count < MAX_RETRIES -> increment retry count, clear timeout count, re-enter REQ_x for the same word;
  - otherwise -> FAIL.
- Same-edge readdatavalid and timeout: data wins, no retry.
- CHECK (1 cycle): match <= (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS); then -> DONE.
- DONE: done=1, busy=0, match held.
- FAIL: error=1, done=0, match=0, busy=0.
- busy=1 in REQ_*, WAIT_*, CHECK.
- Latency, with a zero-wait slave whose readdatavalid arrives 1 cycle after accept: done rises 6 edges after the start edge (REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE).
- Reset mid-sequence: all outputs return to 0 immediately (asynchronous); auto-start follows release.

Test Plan:
- Zero-wait slave returning 32'h04000000 at address 0 and 1417733210 at address 1, readdatavalid 1 cycle after accept -> done=1 and match=1 at edge 6 after reset release; id_value/ts_value equal those words; no m_read glitches.
- Slave returns ts 1417733211 -> done=1, match=0, error=0, ts_value=1417733211.
- m_waitrequest held high 3 cycles on the ID read -> m_read and m_address=0 stable through the stall; done asserts 3 cycles later than the zero-wait case; match=1.
- Timestamp read never responds, TIMEOUT_CYCLES=8, MAX_RETRIES=2 -> exactly 3 timestamp attempts of 8 cycles each, then error=1, done=0, busy=0; id_value still valid.
- After a FAIL, pulse start with a healthy slave -> error clears on the start edge, done=1, match=1. A start pulse while busy has no effect.
- Assert reset_n low during WAIT_TS -> all outputs 0 within the same cycle. After release, a full sequence completes with match=1. A late readdatavalid during REQ_ID is ignored.
